// File: rtl/expr_sched.sv
// expr_sched: six-output arithmetic group evaluated over a 14-step shared
// MUL/ADD schedule. Optional abort port pair under EXPR_SCHED_ABORT_EN.
module expr_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] t,
`ifdef EXPR_SCHED_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6
);

  typedef enum logic [4:0] {
    IDLE, S1, S2, S3, S4, S5, S6, S7,
    S8, S9, S10, S11, S12, S13, S14, DONE
  } state_t;

  state_t state, nxt;

  logic [WIDTH-1:0] cx, cy, cz, cp, cq, cr, cs, ct;
  logic [WIDTH-1:0] xy, zp, qr, ta, tb, tc;
  logic [WIDTH-1:0] r1, r2, r4, r5, r6;

  logic [WIDTH-1:0] ma, mb, aa, ab;
  logic             sub;
  logic [WIDTH-1:0] mres, ares;
  logic             kill;

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = ~ready;
  assign done  = (state == DONE);

`ifdef EXPR_SCHED_ABORT_EN
  assign kill = abort & busy;
`else
  assign kill = 1'b0;
`endif

  assign mres = ma * mb;
  assign ares = sub ? aa - ab : aa + ab;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state: accept in IDLE/DONE, abort kills, else step forward
  always_comb begin
    nxt = state;
    unique case (1'b1)
      ready:   nxt = start ? S1 : IDLE;
      kill:    nxt = IDLE;
      default: nxt = state_t'(state + 5'd1);
    endcase
  end

  // operand steering for the shared multiplier and adder
  always_comb begin
    ma  = '0;
    mb  = '0;
    aa  = '0;
    ab  = '0;
    sub = 1'b0;
    case (state)
      S1:  begin ma = cx; mb = cy; aa = cz; ab = cp; end
      S2:  begin aa = cq; ab = cr; sub = 1'b1; end
      S3:  begin ma = zp; mb = qr; aa = xy; ab = zp; end
      S4:  begin aa = xy; ab = cq; end
      S5:  begin aa = cp; ab = cx; end
      S6:  begin ma = ta; mb = tb; aa = cx; ab = cy; end
      S7:  begin aa = tc; ab = cp; end
      S8:  begin ma = tc; mb = qr; aa = cr; ab = cp; end
      S9:  begin aa = ta; ab = cx; end
      S10: begin aa = xy; ab = cp; end
      S11: begin aa = tb; ab = ta; sub = 1'b1; end
      S12: begin aa = cy; ab = cs; end
      S13: begin aa = ta; ab = cx; end
      S14: begin aa = ta; ab = ct; end
      default: ;
    endcase
  end

  // operand capture on the accepting edge only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {cx, cy, cz, cp} <= '0;
      {cq, cr, cs, ct} <= '0;
    end else if (start && ready) begin
      cx <= x; cy <= y; cz <= z; cp <= p;
      cq <= q; cr <= r; cs <= s; ct <= t;
    end
  end

  // temp and partial-result writeback per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {xy, zp, qr, ta, tb, tc} <= '0;
      {r1, r2, r4, r5, r6} <= '0;
    end else begin
      case (state)
        S1:  begin xy <= mres; zp <= ares; end
        S2:  qr <= ares;
        S3:  begin r2 <= mres; r1 <= ares; end
        S4:  ta <= ares;
        S5:  tb <= ares;
        S6:  begin r4 <= mres; tc <= ares; end
        S7:  tc <= ares;
        S8:  begin r6 <= mres; ta <= ares; end
        S9:  ta <= ares;
        S10: tb <= ares;
        S11: r5 <= ares;
        S12: ta <= ares;
        S13: ta <= ares;
        default: ;
      endcase
    end
  end

  // all six outputs commit together; r3 comes straight off the adder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {out1, out2, out3} <= '0;
      {out4, out5, out6} <= '0;
    end else if (state == S14 && !kill) begin
      out1 <= r1;
      out2 <= r2;
      out3 <= ares;
      out4 <= r4;
      out5 <= r5;
      out6 <= r6;
    end
  end

`ifdef EXPR_SCHED_ABORT_EN
  // one-cycle flag after a busy job is killed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted <= 1'b0;
    else        aborted <= kill;
  end
`endif

endmodule

// File: tb/tb_expr_sched.sv
// tb_expr_sched: random and directed jobs against a formula-level model.
// Define EXPR_SCHED_ABORT_EN to also exercise the abort port pair.
module tb_expr_sched;
  localparam int W = 32;
  typedef logic [W-1:0] word_t;
  typedef struct packed {
    word_t x, y, z, p, q, r, s, t;
  } ops_t;
  typedef logic [5:0][W-1:0] res_t;

  logic  clk = 0, rst_n = 0, start = 0;
  word_t x = 0, y = 0, z = 0, p = 0;
  word_t q = 0, r = 0, s = 0, t = 0;
  logic  abort = 0;
  logic  ready, busy, done;
  word_t out1, out2, out3, out4, out5, out6;
`ifdef EXPR_SCHED_ABORT_EN
  logic  aborted;
`endif

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  expr_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x(x), .y(y), .z(z), .p(p),
    .q(q), .r(r), .s(s), .t(t),
`ifdef EXPR_SCHED_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .ready(ready), .busy(busy), .done(done),
    .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6)
  );

  function automatic res_t eval(ops_t o);
    res_t e;
    word_t xy;
    xy   = o.x * o.y;
    e[0] = xy + (o.z + o.p);
    e[1] = (o.z + o.p) * (o.q - o.r);
    e[2] = o.y + o.s + o.x + o.t;
    e[3] = (xy + o.q) * (o.p + o.x);
    e[4] = (xy + o.p) - (o.r + o.p + o.x);
    e[5] = (o.x + o.y + o.p) * (o.q - o.r);
    return e;
  endfunction

  task automatic chk(string name, word_t act, word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic ops_t pins();
    return {x, y, z, p, q, r, s, t};
  endfunction

  task automatic setops(ops_t o);
    x = o.x; y = o.y; z = o.z; p = o.p;
    q = o.q; r = o.r; s = o.s; t = o.t;
  endtask

  function automatic ops_t rnd();
    ops_t o;
    o = {$urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 3) == 0) o.x = '1;
    if ($urandom_range(0, 3) == 0) o.r = '1;
    return o;
  endfunction

  // model: phase 0 idle, 1..14 busy, 15 done
  int   phase = 0;
  ops_t cap = '0;
  res_t mout = '0;
  logic mab = 0;
  logic en = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0;
      mout  <= '0;
      mab   <= 0;
    end else begin
      mab <= 0;
`ifdef EXPR_SCHED_ABORT_EN
      if (phase >= 1 && phase <= 14 && abort) begin
        phase <= 0;
        mab   <= 1;
      end else
`endif
      if (phase >= 1 && phase <= 13) phase <= phase + 1;
      else if (phase == 14) begin
        mout  <= eval(cap);
        phase <= 15;
      end else if (start) begin
        cap   <= pins();
        phase <= 1;
      end else phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (en && rst_n) begin
      chk("ready", W'(ready), W'(phase == 0 || phase == 15));
      chk("busy", W'(busy), W'(phase >= 1 && phase <= 14));
      chk("done", W'(done), W'(phase == 15));
      chk("out1", out1, mout[0]);
      chk("out2", out2, mout[1]);
      chk("out3", out3, mout[2]);
      chk("out4", out4, mout[3]);
      chk("out5", out5, mout[4]);
      chk("out6", out6, mout[5]);
`ifdef EXPR_SCHED_ABORT_EN
      chk("aborted", W'(aborted), W'(mab));
`endif
    end
  end

  task automatic run(ops_t o, output int dc, output int bc);
    setops(o);
    start = 1;
    dc = -1;
    bc = 0;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      @(negedge clk);
      start = 0;
      if (busy) bc++;
      if (done) dc = c;
    end
  endtask

  task automatic run_scramble(ops_t o);
    res_t e;
    int   dc;
    e = eval(o);
    setops(o);
    start = 1;
    dc = -1;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      @(negedge clk);
      if (done) begin
        dc = c;
        start = 0;
      end else begin
        setops(rnd());
        start = 1'($urandom_range(0, 1));
      end
    end
    chk("scr_done_cycle", W'(dc), 15);
    chk("scr_out1", out1, e[0]);
    chk("scr_out5", out5, e[4]);
    chk("scr_out6", out6, e[5]);
  endtask

  ops_t t1, wr, a, b;
  int   dc, bc, d1, d2;
  res_t e;

  initial begin
    t1 = {32'd2, 32'd3, 32'd4, 32'd5, 32'd10, 32'd7, 32'd1, 32'd6};
    wr = '0;
    wr.x = 32'h10000;
    wr.y = 32'h10000;
    wr.q = 32'd1;

    repeat (3) @(negedge clk);
    chk("rst_ready", W'(ready), 1);
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_out1", out1, 0);
    chk("rst_out5", out5, 0);
    rst_n = 1;
    en = 1;
    @(negedge clk);

    run(t1, dc, bc);
    chk("t1_done_cycle", W'(dc), 15);
    chk("t1_busy_cycles", W'(bc), 14);
    chk("t1_out1", out1, 15);
    chk("t1_out2", out2, 27);
    chk("t1_out3", out3, 12);
    chk("t1_out4", out4, 112);
    chk("t1_out5", out5, 32'hFFFFFFFD);
    chk("t1_out6", out6, 30);
    @(negedge clk);
    chk("t1_hold_out4", out4, 112);

    run(wr, dc, bc);
    chk("wr_out1", out1, 0);
    chk("wr_out2", out2, 0);
    chk("wr_out4", out4, 32'h10000);
    chk("wr_out5", out5, 32'hFFFF0000);
    @(negedge clk);

    a = rnd();
    b = rnd();
    setops(a);
    start = 1;
    d1 = -1;
    d2 = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done && d1 < 0) d1 = c;
      else if (done) d2 = c;
      if (c == 1) setops(b);
      if (c == 30) start = 0;
    end
    e = eval(b);
    chk("b2b_done1", W'(d1), 15);
    chk("b2b_done2", W'(d2), 30);
    chk("b2b_out2", out2, e[1]);
    chk("b2b_out4", out4, e[3]);
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      run_scramble(rnd());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    setops(rnd());
    start = 1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 0;
    end
    chk("s7_busy", W'(busy), 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_out1", out1, 0);
    chk("mid_rst_out3", out3, 0);
    chk("mid_rst_out6", out6, 0);
    chk("mid_rst_ready", W'(ready), 1);
    chk("mid_rst_done", W'(done), 0);
    @(negedge clk);
    chk("mid_rst_nodone", W'(done), 0);
    rst_n = 1;
    @(negedge clk);
    run(t1, dc, bc);
    chk("post_rst_done_cycle", W'(dc), 15);
    chk("post_rst_out4", out4, 112);
    @(negedge clk);

`ifdef EXPR_SCHED_ABORT_EN
    setops(rnd());
    start = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 0;
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("ab_aborted", W'(aborted), 1);
    chk("ab_ready", W'(ready), 1);
    chk("ab_done", W'(done), 0);
    chk("ab_out1", out1, 15);
    chk("ab_out2", out2, 27);
    chk("ab_out3", out3, 12);
    chk("ab_out4", out4, 112);
    chk("ab_out5", out5, 32'hFFFFFFFD);
    chk("ab_out6", out6, 30);
    @(negedge clk);
    chk("ab_pulse_end", W'(aborted), 0);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
